// File: rtl/alarm_pkg.sv
// Shared types for the alarm sequencer: state encoding, keypad code classes
// and the default arm/disarm codes.
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4
    } alarm_state_t;

    typedef enum logic [1:0] {
        CODE_NONE,
        CODE_ARM,
        CODE_DIS,
        CODE_BAD
    } code_class_t;

    localparam logic [4:0] DEFAULT_ARM_CODE    = 5'b10000;
    localparam logic [4:0] DEFAULT_DISARM_CODE = 5'b00100;

    // Anything submitted that is neither the arm nor the disarm code is bad.
    function automatic code_class_t classify_code(input logic       ev,
                                                  input logic [4:0] code,
                                                  input logic [4:0] arm_code,
                                                  input logic [4:0] dis_code);
        if (!ev)
            return CODE_NONE;
        else if (code == arm_code)
            return CODE_ARM;
        else if (code == dis_code)
            return CODE_DIS;
        else
            return CODE_BAD;
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by the exit, entry and siren delays.
// Holds at zero once expired so an idle timer never wraps.
module alarm_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          en_i,
    output logic          expired_o
);

    logic [TW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else if (load_i)
            count_q <= load_val_i;
        else if (en_i && (count_q != '0))
            count_q <= count_q - 1'b1;
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/alarm_seq_ctrl.sv
// Alarm sequencer: arm/disarm by keypad, exit and entry delays, bounded siren
// and lockout after repeated wrong codes while armed.
module alarm_seq_ctrl
    import alarm_pkg::*;
#(
    parameter logic [4:0] ARM_CODE     = DEFAULT_ARM_CODE,
    parameter logic [4:0] DISARM_CODE  = DEFAULT_DISARM_CODE,
    parameter int         EXIT_CYCLES  = 100,
    parameter int         ENTRY_CYCLES = 50,
    parameter int         SIREN_CYCLES = 200,
    parameter int         MAX_BAD      = 3,
    parameter int         TW           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m1,
    input  logic       m2,
    input  logic       r,
    input  logic [4:0] k,
    output logic       active,
    output logic       alarm,
    output logic       pending,
    output logic [2:0] state
);

    localparam int BW = $clog2(MAX_BAD + 1);
    localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_CYCLES - 1);
    localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_CYCLES - 1);
    localparam logic [TW-1:0] SIREN_LOAD = TW'(SIREN_CYCLES - 1);

    alarm_state_t  state_q, state_d;
    logic [BW-1:0] bad_q, bad_d;
    logic          r_q;
    logic          active_q, alarm_q, pending_q;

    code_class_t   code_cls;
    logic          bad_hit;
    logic [BW-1:0] bad_inc;
    logic          tmr_load, tmr_en, tmr_expired;
    logic [TW-1:0] tmr_load_val;

    alarm_timer #(.TW(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .expired_o  (tmr_expired)
    );

    assign code_cls = classify_code(r & ~r_q, k, ARM_CODE, DISARM_CODE);
    assign bad_hit  = (code_cls == CODE_BAD) && ((int'(bad_q) + 1) >= MAX_BAD);
    assign bad_inc  = (int'(bad_q) < MAX_BAD) ? bad_q + 1'b1 : bad_q;
    assign tmr_en   = (state_q == ST_EXIT_DELAY) || (state_q == ST_ENTRY_DELAY) ||
                      (state_q == ST_ALARM);

    // Priority inside each state: disarm, bad-code lockout, expiry, motion.
    always_comb begin
        state_d      = state_q;
        bad_d        = bad_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            ST_DISARMED: begin
                if (code_cls == CODE_ARM)
                    state_d = ST_EXIT_DELAY;
            end
            ST_EXIT_DELAY: begin
                if (code_cls == CODE_DIS)
                    state_d = ST_DISARMED;
                else if (tmr_expired)
                    state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (code_cls == CODE_DIS)
                    state_d = ST_DISARMED;
                else if (bad_hit)
                    state_d = ST_ALARM;
                else begin
                    if (code_cls == CODE_BAD)
                        bad_d = bad_inc;
                    if (m1 || m2)
                        state_d = ST_ENTRY_DELAY;
                end
            end
            ST_ENTRY_DELAY: begin
                if (code_cls == CODE_DIS)
                    state_d = ST_DISARMED;
                else if (bad_hit)
                    state_d = ST_ALARM;
                else begin
                    if (code_cls == CODE_BAD)
                        bad_d = bad_inc;
                    if (tmr_expired)
                        state_d = ST_ALARM;
                end
            end
            ST_ALARM: begin
                if (code_cls == CODE_DIS)
                    state_d = ST_DISARMED;
                else if (tmr_expired)
                    state_d = ST_ARMED;
            end
            default: state_d = ST_DISARMED;
        endcase

        if ((state_d == ST_DISARMED) || ((state_d == ST_ALARM) && (state_q != ST_ALARM)))
            bad_d = '0;

        if (state_d != state_q) begin
            case (state_d)
                ST_EXIT_DELAY:  begin tmr_load = 1'b1; tmr_load_val = EXIT_LOAD;  end
                ST_ENTRY_DELAY: begin tmr_load = 1'b1; tmr_load_val = ENTRY_LOAD; end
                ST_ALARM:       begin tmr_load = 1'b1; tmr_load_val = SIREN_LOAD; end
                default:        tmr_load = 1'b0;
            endcase
        end
    end

    // Outputs are registered from the next state so they move on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_DISARMED;
            bad_q     <= '0;
            r_q       <= 1'b0;
            active_q  <= 1'b0;
            alarm_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bad_q     <= bad_d;
            r_q       <= r;
            active_q  <= (state_d != ST_DISARMED);
            alarm_q   <= (state_d == ST_ALARM);
            pending_q <= (state_d == ST_EXIT_DELAY) || (state_d == ST_ENTRY_DELAY);
        end
    end

    assign active  = active_q;
    assign alarm   = alarm_q;
    assign pending = pending_q;
    assign state   = state_q;

endmodule

// File: tb/tb_alarm_seq_ctrl.sv
// Self-checking bench for alarm_seq_ctrl: directed scenarios followed by random
// traffic, all compared every cycle against a delay/elapsed-time reference model.
module tb_alarm_seq_ctrl;

    localparam int EXIT_C  = 4;
    localparam int ENTRY_C = 3;
    localparam int SIREN_C = 5;
    localparam int MAX_B   = 3;
    localparam logic [4:0] ARM_K = 5'b10000;
    localparam logic [4:0] DIS_K = 5'b00100;
    localparam int S_DIS = 0, S_EXIT = 1, S_ARMED = 2, S_ENTRY = 3, S_ALARM = 4;

    logic       clk = 1'b0;
    logic       rst, m1, m2, r;
    logic [4:0] k;
    logic       active, alarm, pending;
    logic [2:0] state;

    int compareCount = 0;
    int failCount    = 0;

    int mState, mElapsed, mBad;
    bit mRPrev;

    always #5 clk = ~clk;

    alarm_seq_ctrl #(
        .ARM_CODE     (ARM_K),
        .DISARM_CODE  (DIS_K),
        .EXIT_CYCLES  (EXIT_C),
        .ENTRY_CYCLES (ENTRY_C),
        .SIREN_CYCLES (SIREN_C),
        .MAX_BAD      (MAX_B),
        .TW           (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m1      (m1),
        .m2      (m2),
        .r       (r),
        .k       (k),
        .active  (active),
        .alarm   (alarm),
        .pending (pending),
        .state   (state)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model counts cycles elapsed since entering the current state.
    function void modelStep();
        bit ev, isArm, isDis, isBad, expiry;
        int nxt;
        if (rst) begin
            mState = S_DIS; mElapsed = 0; mBad = 0; mRPrev = 0;
            return;
        end
        ev     = r && !mRPrev;
        mRPrev = r;
        isArm  = ev && (k == ARM_K);
        isDis  = ev && (k == DIS_K);
        isBad  = ev && !isArm && !isDis;
        mElapsed++;
        expiry = (mState == S_EXIT  && mElapsed >= EXIT_C)  ||
                 (mState == S_ENTRY && mElapsed >= ENTRY_C) ||
                 (mState == S_ALARM && mElapsed >= SIREN_C);
        if (isBad && (mState == S_ARMED || mState == S_ENTRY))
            mBad++;
        nxt = mState;
        if (mState == S_DIS) begin
            if (isArm) nxt = S_EXIT;
        end else if (isDis)
            nxt = S_DIS;
        else if ((mState == S_ARMED || mState == S_ENTRY) && isBad && mBad >= MAX_B)
            nxt = S_ALARM;
        else if (expiry)
            nxt = (mState == S_ENTRY) ? S_ALARM : S_ARMED;
        else if (mState == S_ARMED && (m1 || m2))
            nxt = S_ENTRY;
        if (nxt == S_DIS || (nxt == S_ALARM && mState != S_ALARM))
            mBad = 0;
        if (nxt != mState)
            mElapsed = 0;
        mState = nxt;
    endfunction

    task automatic applyStimulus(input bit rstV, input bit m1V, input bit m2V,
                                 input bit rV, input logic [4:0] kV);
        @(negedge clk);
        rst = rstV; m1 = m1V; m2 = m2V; r = rV; k = kV;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("state",   {5'b0, state},   8'(mState));
        checkOutput("active",  {7'b0, active},  {7'b0, mState != S_DIS});
        checkOutput("alarm",   {7'b0, alarm},   {7'b0, mState == S_ALARM});
        checkOutput("pending", {7'b0, pending}, {7'b0, (mState == S_EXIT) || (mState == S_ENTRY)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 5'b00000);
    endtask

    task automatic codePulse(input logic [4:0] code);
        applyStimulus(0, 0, 0, 1, code);
        applyStimulus(0, 0, 0, 0, code);
    endtask

    initial begin
        logic [4:0] rk;
        rst = 1'b1; m1 = 1'b0; m2 = 1'b0; r = 1'b0; k = 5'b0;
        mState = S_DIS; mElapsed = 0; mBad = 0; mRPrev = 0;

        applyStimulus(1, 0, 0, 0, 5'b0);
        checkOutput("resetState", {5'b0, state}, 8'd0);

        // Arm, motion during exit delay is ignored, armed after 4 edges
        applyStimulus(0, 0, 0, 1, ARM_K);
        checkOutput("armPending", {7'b0, pending}, 8'd1);
        applyStimulus(0, 1, 0, 0, 5'b0);
        idle(2);
        checkOutput("exitStill", {5'b0, state}, 8'd1);
        idle(1);
        checkOutput("armedState", {5'b0, state}, 8'd2);
        checkOutput("armedPending", {7'b0, pending}, 8'd0);

        // Intrusion: alarm at t+3, siren ends at t+8
        applyStimulus(0, 0, 1, 0, 5'b0);
        checkOutput("entryState", {5'b0, state}, 8'd3);
        idle(2);
        checkOutput("noAlarmYet", {7'b0, alarm}, 8'd0);
        idle(1);
        checkOutput("alarmOn", {7'b0, alarm}, 8'd1);
        idle(4);
        checkOutput("sirenHeld", {7'b0, alarm}, 8'd1);
        idle(1);
        checkOutput("sirenOff", {7'b0, alarm}, 8'd0);
        checkOutput("rearmed", {5'b0, state}, 8'd2);

        // Disarm during entry delay
        applyStimulus(0, 1, 0, 0, 5'b0);
        applyStimulus(0, 0, 0, 1, DIS_K);
        checkOutput("disEntry", {5'b0, state}, 8'd0);
        idle(4);
        checkOutput("noLateAlarm", {7'b0, alarm}, 8'd0);

        // Bad-code lockout; arm code in between is not counted
        codePulse(ARM_K);
        idle(3);
        codePulse(5'b00001);
        codePulse(ARM_K);
        codePulse(5'b11111);
        checkOutput("twoBad", {5'b0, state}, 8'd2);
        applyStimulus(0, 0, 0, 1, 5'b00010);
        checkOutput("lockout", {7'b0, alarm}, 8'd1);
        applyStimulus(0, 0, 0, 0, 5'b0);

        // Reset mid-siren with r held: post-reset disarm event is ignored
        applyStimulus(1, 0, 0, 1, DIS_K);
        checkOutput("rstAlarm", {7'b0, alarm}, 8'd0);
        checkOutput("rstState", {5'b0, state}, 8'd0);
        applyStimulus(0, 0, 0, 1, DIS_K);
        applyStimulus(0, 0, 0, 0, DIS_K);
        checkOutput("postRst", {5'b0, state}, 8'd0);

        // Disarm on the exact entry-delay expiry edge
        codePulse(ARM_K);
        idle(3);
        applyStimulus(0, 1, 0, 0, 5'b0);
        idle(2);
        applyStimulus(0, 0, 0, 1, DIS_K);
        checkOutput("disBeatsExpiry", {5'b0, state}, 8'd0);
        checkOutput("noAlarmExpiry", {7'b0, alarm}, 8'd0);
        applyStimulus(0, 0, 0, 0, 5'b0);

        // r held 10 cycles: one arm event only, later disarm code not seen
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, (i < 5) ? ARM_K : DIS_K);
        checkOutput("heldR", {5'b0, state}, 8'd2);
        applyStimulus(0, 0, 0, 0, 5'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: rk = ARM_K;
                3:       rk = DIS_K;
                default: rk = 5'($urandom);
            endcase
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
                          ($urandom_range(0, 24) == 0), ($urandom_range(0, 5) == 0), rk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", compareCount, failCount);
        $finish;
    end

endmodule
